// File: rtl/id_stage_fwd_pkg.sv
// Shared encodings for the ID stage: MIPS opcode/funct fields, ALU op/select codes
// and register/word constants used by the decoder and the stage top.
package id_stage_fwd_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_PREF    = 6'b110011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_SYNC = 6'b001111;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;

  localparam logic [7:0] ALU_NOP_OP = 8'b00000000;
  localparam logic [7:0] ALU_AND_OP = 8'b00100100;
  localparam logic [7:0] ALU_OR_OP  = 8'b00100101;
  localparam logic [7:0] ALU_XOR_OP = 8'b00100110;
  localparam logic [7:0] ALU_NOR_OP = 8'b00100111;
  localparam logic [7:0] ALU_SLL_OP = 8'b01111100;
  localparam logic [7:0] ALU_SRL_OP = 8'b00000010;
  localparam logic [7:0] ALU_SRA_OP = 8'b00000011;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;

  localparam logic [4:0]  NOP_REG_ADDR = 5'b00000;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

endpackage

// File: rtl/id_decoder.sv
// Pure combinational decode of the logic/shift/immediate MIPS subset into ALU
// controls, register-read enables, immediate operand and destination.
module id_decoder
  import id_stage_fwd_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic [31:0]         i_inst,
  output logic [ALUOP_W-1:0]  o_aluop,
  output logic [ALUSEL_W-1:0] o_alusel,
  output logic                o_re1,
  output logic                o_re2,
  output logic [DATA_W-1:0]   o_imm,
  output logic [REG_AW-1:0]   o_wd,
  output logic                o_wreg,
  output logic                o_invalid
);

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_sa;
  logic [15:0] w_imm16;

  assign w_op    = i_inst[31:26];
  assign w_rs    = i_inst[25:21];
  assign w_rt    = i_inst[20:16];
  assign w_rd    = i_inst[15:11];
  assign w_sa    = i_inst[10:6];
  assign w_funct = i_inst[5:0];
  assign w_imm16 = i_inst[15:0];

  always_comb begin
    o_aluop   = ALUOP_W'(ALU_NOP_OP);
    o_alusel  = ALUSEL_W'(SEL_NOP);
    o_re1     = 1'b0;
    o_re2     = 1'b0;
    o_imm     = DATA_W'(ZERO_WORD);
    o_wd      = REG_AW'(w_rd);
    o_wreg    = 1'b0;
    o_invalid = 1'b1;
    case (w_op)
      OP_SPECIAL: begin
        case (w_funct)
          F_AND, F_OR, F_XOR, F_NOR: begin
            o_aluop   = ALUOP_W'({2'b00, w_funct});
            o_alusel  = ALUSEL_W'(SEL_LOGIC);
            o_re1     = 1'b1;
            o_re2     = 1'b1;
            o_wreg    = 1'b1;
            o_invalid = 1'b0;
          end
          F_SLLV, F_SRLV, F_SRAV: begin
            o_aluop   = (w_funct == F_SLLV) ? ALUOP_W'(ALU_SLL_OP) :
                        (w_funct == F_SRLV) ? ALUOP_W'(ALU_SRL_OP) : ALUOP_W'(ALU_SRA_OP);
            o_alusel  = ALUSEL_W'(SEL_SHIFT);
            o_re1     = 1'b1;
            o_re2     = 1'b1;
            o_wreg    = 1'b1;
            o_invalid = 1'b0;
          end
          F_SYNC: o_invalid = 1'b0;
          F_SLL, F_SRL, F_SRA: begin
            // Constant shifts reuse the rs field as must-be-zero; shamt rides in imm.
            if (w_rs == 5'd0) begin
              o_aluop   = (w_funct == F_SLL) ? ALUOP_W'(ALU_SLL_OP) :
                          (w_funct == F_SRL) ? ALUOP_W'(ALU_SRL_OP) : ALUOP_W'(ALU_SRA_OP);
              o_alusel  = ALUSEL_W'(SEL_SHIFT);
              o_re2     = 1'b1;
              o_imm     = DATA_W'(w_sa);
              o_wreg    = 1'b1;
              o_invalid = 1'b0;
            end
          end
          default: ;
        endcase
      end
      OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
        o_aluop   = (w_op == OP_ANDI) ? ALUOP_W'(ALU_AND_OP) :
                    (w_op == OP_XORI) ? ALUOP_W'(ALU_XOR_OP) : ALUOP_W'(ALU_OR_OP);
        o_alusel  = ALUSEL_W'(SEL_LOGIC);
        o_re1     = 1'b1;
        o_imm     = (w_op == OP_LUI) ? DATA_W'({w_imm16, 16'h0000}) : DATA_W'(w_imm16);
        o_wd      = REG_AW'(w_rt);
        o_wreg    = 1'b1;
        o_invalid = 1'b0;
      end
      OP_PREF: o_invalid = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: rtl/id_stage_fwd.sv
// Registered decode stage: prioritised operand forwarding, load-use hazard detection,
// ID/EX register with valid/ready on both sides, and a saturating stall counter.
module id_stage_fwd
  import id_stage_fwd_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int FWD_N    = 2,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        pc_i,
  input  logic [31:0]              inst_i,
  output logic                     reg1_read_o,
  output logic [REG_AW-1:0]        reg1_addr_o,
  output logic                     reg2_read_o,
  output logic [REG_AW-1:0]        reg2_addr_o,
  input  logic [DATA_W-1:0]        reg1_data_i,
  input  logic [DATA_W-1:0]        reg2_data_i,
  input  logic [FWD_N-1:0]         fwd_wreg_i,
  input  logic [FWD_N*REG_AW-1:0]  fwd_wd_i,
  input  logic [FWD_N*DATA_W-1:0]  fwd_wdata_i,
  input  logic [FWD_N-1:0]         fwd_is_load_i,
  input  logic                     flush_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        pc_o,
  output logic [ALUOP_W-1:0]       aluop_o,
  output logic [ALUSEL_W-1:0]      alusel_o,
  output logic [DATA_W-1:0]        reg1_o,
  output logic [DATA_W-1:0]        reg2_o,
  output logic [REG_AW-1:0]        wd_o,
  output logic                     wreg_o,
  output logic                     inst_invalid_o,
  output logic                     stall_req_o,
  output logic [15:0]              stall_cnt_o
);

  logic [ALUOP_W-1:0]  w_aluop;
  logic [ALUSEL_W-1:0] w_alusel;
  logic                w_re1;
  logic                w_re2;
  logic [DATA_W-1:0]   w_imm;
  logic [REG_AW-1:0]   w_wd;
  logic                w_wreg;
  logic                w_invalid;
  logic                w_hazard;
  logic                w_accept;

  logic                r_valid;
  logic [DATA_W-1:0]   r_pc;
  logic [ALUOP_W-1:0]  r_aluop;
  logic [ALUSEL_W-1:0] r_alusel;
  logic [DATA_W-1:0]   r_reg1;
  logic [DATA_W-1:0]   r_reg2;
  logic [REG_AW-1:0]   r_wd;
  logic                r_wreg;
  logic                r_invalid;
  logic [15:0]         r_stall_cnt;

  id_decoder #(
    .DATA_W   (DATA_W),
    .REG_AW   (REG_AW),
    .ALUOP_W  (ALUOP_W),
    .ALUSEL_W (ALUSEL_W)
  ) u_dec (
    .i_inst    (inst_i),
    .o_aluop   (w_aluop),
    .o_alusel  (w_alusel),
    .o_re1     (w_re1),
    .o_re2     (w_re2),
    .o_imm     (w_imm),
    .o_wd      (w_wd),
    .o_wreg    (w_wreg),
    .o_invalid (w_invalid)
  );

  assign reg1_read_o = w_re1;
  assign reg2_read_o = w_re2;
  assign reg1_addr_o = REG_AW'(inst_i[25:21]);
  assign reg2_addr_o = REG_AW'(inst_i[20:16]);

  // One mux per operand; scanning channels high-to-low leaves the lowest matching index in place.
  for (genvar s = 0; s < 2; s++) begin : g_opnd
    logic              w_re;
    logic [REG_AW-1:0] w_addr;
    logic [DATA_W-1:0] w_rf;
    logic [DATA_W-1:0] w_fwd;
    logic [DATA_W-1:0] w_val;
    logic              w_hit;
    logic              w_ld;
    logic              w_haz;

    assign w_re   = (s == 0) ? reg1_read_o : reg2_read_o;
    assign w_addr = (s == 0) ? reg1_addr_o : reg2_addr_o;
    assign w_rf   = (s == 0) ? reg1_data_i : reg2_data_i;

    always_comb begin
      w_hit = 1'b0;
      w_ld  = 1'b0;
      w_fwd = w_rf;
      for (int k = FWD_N - 1; k >= 0; k--) begin
        if (fwd_wreg_i[k] && (fwd_wd_i[k*REG_AW +: REG_AW] == w_addr)) begin
          w_hit = 1'b1;
          w_ld  = fwd_is_load_i[k];
          w_fwd = fwd_wdata_i[k*DATA_W +: DATA_W];
        end
      end
    end

    always_comb begin
      w_val = w_fwd;
      w_haz = 1'b0;
      if (!w_re) begin
        w_val = w_imm;
      end else if (w_addr == REG_AW'(NOP_REG_ADDR)) begin
        w_val = '0;
      end else begin
        w_haz = w_hit && w_ld;
      end
    end
  end

  assign w_hazard    = g_opnd[0].w_haz | g_opnd[1].w_haz;
  assign stall_req_o = w_hazard;

  // Handshake: a transfer happens on a cycle where valid && ready are both high.
  // in_ready never depends on in_valid; out_valid never drops while out_ready is low
  // except through flush_i or rst.
  assign in_ready = !w_hazard && (!r_valid || out_ready) && !flush_i;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_aluop   <= '0;
      r_alusel  <= '0;
      r_reg1    <= '0;
      r_reg2    <= '0;
      r_wd      <= '0;
      r_wreg    <= 1'b0;
      r_invalid <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_pc      <= pc_i;
      r_aluop   <= w_aluop;
      r_alusel  <= w_alusel;
      r_reg1    <= g_opnd[0].w_val;
      r_reg2    <= g_opnd[1].w_val;
      r_wd      <= w_wd;
      r_wreg    <= w_wreg;
      r_invalid <= w_invalid;
    end else if (!r_valid || out_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 16'h0000;
    end else if (stall_req_o && in_valid && !flush_i && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign out_valid      = r_valid;
  assign pc_o           = r_pc;
  assign aluop_o        = r_aluop;
  assign alusel_o       = r_alusel;
  assign reg1_o         = r_reg1;
  assign reg2_o         = r_reg2;
  assign wd_o           = r_wd;
  assign wreg_o         = r_wreg;
  assign inst_invalid_o = r_invalid;
  assign stall_cnt_o    = r_stall_cnt;

endmodule

// File: tb/tb_id_stage_fwd.sv
// Directed bench for id_stage_fwd: decode, forwarding priority, load-use stall,
// hold/flush handshake and reset, with hand-computed expectations.
module tb_id_stage_fwd;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int FWD_N    = 2;
  localparam int ALUOP_W  = 8;
  localparam int ALUSEL_W = 3;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       pc_i;
  logic [31:0]             inst_i;
  logic                    reg1_read_o;
  logic [REG_AW-1:0]       reg1_addr_o;
  logic                    reg2_read_o;
  logic [REG_AW-1:0]       reg2_addr_o;
  logic [DATA_W-1:0]       reg1_data_i;
  logic [DATA_W-1:0]       reg2_data_i;
  logic [FWD_N-1:0]        fwd_wreg_i;
  logic [FWD_N*REG_AW-1:0] fwd_wd_i;
  logic [FWD_N*DATA_W-1:0] fwd_wdata_i;
  logic [FWD_N-1:0]        fwd_is_load_i;
  logic                    flush_i;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       pc_o;
  logic [ALUOP_W-1:0]      aluop_o;
  logic [ALUSEL_W-1:0]     alusel_o;
  logic [DATA_W-1:0]       reg1_o;
  logic [DATA_W-1:0]       reg2_o;
  logic [REG_AW-1:0]       wd_o;
  logic                    wreg_o;
  logic                    inst_invalid_o;
  logic                    stall_req_o;
  logic [15:0]             stall_cnt_o;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  id_stage_fwd #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_N(FWD_N), .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .pc_i(pc_i), .inst_i(inst_i),
    .reg1_read_o(reg1_read_o), .reg1_addr_o(reg1_addr_o),
    .reg2_read_o(reg2_read_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
    .fwd_is_load_i(fwd_is_load_i), .flush_i(flush_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_o(pc_o), .aluop_o(aluop_o), .alusel_o(alusel_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .inst_invalid_o(inst_invalid_o), .stall_req_o(stall_req_o), .stall_cnt_o(stall_cnt_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: present an instruction and queue the reg2 operand it should produce
  task automatic send(input logic [31:0] inst, input logic [DATA_W-1:0] exp_reg2);
    in_valid = 1'b1;
    inst_i   = inst;
    pc_i     = pc_i + 32'd4;
    exp_q.push_back(exp_reg2);
  endtask

  // Scoreboard check of one op sitting in the ID/EX register
  task automatic check_op(input string tag, input logic [7:0] aluop, input logic [2:0] alusel,
                          input logic [31:0] reg1, input logic [4:0] wd, input logic wreg);
    logic [DATA_W-1:0] exp_reg2;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".aluop"}, 32'(aluop_o), 32'(aluop));
    chk({tag, ".alusel"}, 32'(alusel_o), 32'(alusel));
    chk({tag, ".reg1"}, reg1_o, reg1);
    chk({tag, ".wd"}, 32'(wd_o), 32'(wd));
    chk({tag, ".wreg"}, 32'(wreg_o), 32'(wreg));
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s.reg2: observed %h expected <queue empty>", tag, reg2_o);
    end else begin
      exp_reg2 = exp_q.pop_front();
      chk({tag, ".reg2"}, reg2_o, exp_reg2);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; inst_i = '0; pc_i = '0;
    reg1_data_i = 32'h12345678; reg2_data_i = 32'h0000F00F;
    fwd_wreg_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0; fwd_is_load_i = '0;
    flush_i = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.stall_cnt", 32'(stall_cnt_o), 32'd0);
    chk("reset.wreg", 32'(wreg_o), 32'd0);
    chk("reset.reg2", reg2_o, 32'd0);
    rst = 1'b0;

    // ORI $1,$0,0x1100
    send(32'h34011100, 32'h00001100);
    #1;
    chk("ori.in_ready", 32'(in_ready), 32'd1);
    chk("ori.reg1_read", 32'(reg1_read_o), 32'd1);
    chk("ori.reg1_addr", 32'(reg1_addr_o), 32'd0);
    chk("ori.reg2_read", 32'(reg2_read_o), 32'd0);
    chk("ori.stall_req", 32'(stall_req_o), 32'd0);
    tick();
    in_valid = 1'b0;
    check_op("ori", 8'h25, 3'd1, 32'h0, 5'd1, 1'b1);
    chk("ori.pc", pc_o, 32'd4);
    tick();
    chk("bubble.out_valid", 32'(out_valid), 32'd0);

    // OR $3,$1,$2: both channels match $1, channel 0 wins
    fwd_wreg_i  = 2'b11;
    fwd_wd_i    = {5'd1, 5'd1};
    fwd_wdata_i = {32'h00005555, 32'hAAAA0000};
    send(32'h00221825, 32'h0000F00F);
    tick();
    check_op("or_ch0", 8'h25, 3'd1, 32'hAAAA0000, 5'd3, 1'b1);
    fwd_wd_i = {5'd1, 5'd4};
    send(32'h00221825, 32'h0000F00F);
    tick();
    check_op("or_ch1", 8'h25, 3'd1, 32'h00005555, 5'd3, 1'b1);

    // $0 is never forwarded nor a hazard source
    fwd_wreg_i    = 2'b01;
    fwd_wd_i      = {5'd0, 5'd0};
    fwd_wdata_i   = {32'h0, 32'h0000DEAD};
    fwd_is_load_i = 2'b01;
    send(32'h00021825, 32'h0000F00F);
    #1;
    chk("zero_src.stall_req", 32'(stall_req_o), 32'd0);
    tick();
    check_op("zero_src", 8'h25, 3'd1, 32'h0, 5'd3, 1'b1);

    // Load-use on $2 via channel 0
    fwd_wd_i    = {5'd0, 5'd2};
    fwd_wdata_i = {32'h0, 32'h0000BEEF};
    send(32'h00452025, 32'h0000F00F);
    #1;
    chk("loaduse.stall_req", 32'(stall_req_o), 32'd1);
    chk("loaduse.in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("loaduse.out_valid", 32'(out_valid), 32'd0);
    chk("loaduse.stall_cnt", 32'(stall_cnt_o), 32'd1);

    // Channel 1 load is shadowed by channel 0 non-load
    fwd_wreg_i    = 2'b11;
    fwd_wd_i      = {5'd2, 5'd2};
    fwd_is_load_i = 2'b10;
    fwd_wdata_i   = {32'h00000099, 32'h00000077};
    #1;
    chk("shadow.stall_req", 32'(stall_req_o), 32'd0);
    chk("shadow.in_ready", 32'(in_ready), 32'd1);
    tick();
    check_op("shadow", 8'h25, 3'd1, 32'h00000077, 5'd4, 1'b1);
    chk("shadow.stall_cnt", 32'(stall_cnt_o), 32'd1);
    fwd_wreg_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0; fwd_is_load_i = '0;

    // Hold with out_ready low, then flush
    out_ready = 1'b0;
    send(32'h34020055, 32'h00000055);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold.out_valid", 32'(out_valid), 32'd1);
      chk("hold.reg1", reg1_o, 32'h00000077);
      chk("hold.wd", 32'(wd_o), 32'd4);
      chk("hold.in_ready", 32'(in_ready), 32'd0);
    end
    flush_i = 1'b1;
    #1;
    chk("flush.in_ready", 32'(in_ready), 32'd0);
    tick();
    flush_i = 1'b0;
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    tick();
    check_op("ori_after_flush", 8'h25, 3'd1, 32'h0, 5'd2, 1'b1);
    out_ready = 1'b1;

    // Unrecognised encoding and SYNC
    send(32'hFC000000, 32'h0);
    tick();
    check_op("invalid", 8'h00, 3'd0, 32'h0, 5'd0, 1'b0);
    chk("invalid.flag", 32'(inst_invalid_o), 32'd1);
    send(32'h0000000F, 32'h0);
    tick();
    check_op("sync", 8'h00, 3'd0, 32'h0, 5'd0, 1'b0);
    chk("sync.flag", 32'(inst_invalid_o), 32'd0);

    // SLL $5,$6,3 and LUI $7,0x1234
    send(32'h000628C0, 32'h0000F00F);
    tick();
    check_op("sll", 8'h7C, 3'd2, 32'h00000003, 5'd5, 1'b1);
    send(32'h3C071234, 32'h12340000);
    tick();
    check_op("lui", 8'h25, 3'd1, 32'h0, 5'd7, 1'b1);

    // Reset while an op is held
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid.out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid.stall_cnt", 32'(stall_cnt_o), 32'd0);
    chk("rst_mid.wreg", 32'(wreg_o), 32'd0);
    chk("rst_mid.aluop", 32'(aluop_o), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
